// File: rtl/tone_pkg.sv
// Shared definitions for the tone decoder and the tone organ: note/state enums,
// per-note full periods in 50 MHz cycles, and the period-to-note matcher.
package tone_pkg;

    localparam int PERIOD_W = 18;
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    typedef enum logic [2:0] {DO, RE, MI, FA, SO, LA, SI, DO2} note_t;

    typedef enum logic [1:0] {SILENT, ARM, MEASURE, LOCKED} state_t;

    localparam logic [PERIOD_W-1:0] FULL_PERIOD [0:7] = '{
        18'd95602, 18'd85178, 18'd75872, 18'd71634,
        18'd63856, 18'd56818, 18'd50658, 18'd47802
    };

    typedef struct packed {
        logic  hit;
        note_t note;
    } match_t;

    // Tolerance is FULL_PERIOD/64; scanning downwards lets the lowest note win overlaps.
    function automatic match_t match_period(input logic [PERIOD_W-1:0] period);
        match_t              m;
        logic [PERIOD_W-1:0] diff;
        m.hit  = 1'b0;
        m.note = DO;
        for (int n = 7; n >= 0; n--) begin
            diff = (period >= FULL_PERIOD[n]) ? period - FULL_PERIOD[n]
                                              : FULL_PERIOD[n] - period;
            if (diff <= (FULL_PERIOD[n] >> 6)) begin
                m.hit  = 1'b1;
                m.note = note_t'(3'(n));
            end
        end
        return m;
    endfunction

    function automatic logic [PERIOD_W-1:0] half_period(input note_t n);
        return FULL_PERIOD[int'(n)] >> 1;
    endfunction

endpackage

// File: rtl/tone_decoder_if.sv
// Tone decoder bus: square-wave input from the organ and decoded results back.
interface tone_decoder_if;
    import tone_pkg::*;

    logic        audio_in;
    note_t       note;
    logic        locked;
    logic        period_valid;
    logic [31:0] info;

    modport master (output audio_in, input note, locked, period_valid, info);
    modport slave  (input audio_in, output note, locked, period_valid, info);

endinterface

// File: rtl/tone_decoder_edge_sync.sv
// Two-flop synchronizer for the asynchronous tone input plus rising-edge detector.
module edge_sync (
    input  logic CLK_50M,
    input  logic RESET_N,
    input  logic async_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge CLK_50M) begin
        if (!RESET_N) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= async_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of the organ's square wave and locks onto a note after two
// consecutive matching periods. Define TONE_DECODER_INFO_EN to expose the period on info.
module tone_decoder
    import tone_pkg::*;
(
    input  logic           CLK_50M,
    input  logic           RESET_N,
    tone_decoder_if.slave  bus
);

    logic                rise;
    logic [PERIOD_W-1:0] count;
    logic                saturated;
    logic                capture;
    match_t              cur_match;
    state_t              state;
    note_t               cand;
    note_t               note_q;
    logic                locked_q;
    logic                period_valid_q;

    edge_sync u_edge_sync (
        .CLK_50M  (CLK_50M),
        .RESET_N  (RESET_N),
        .async_in (bus.audio_in),
        .rise     (rise)
    );

    // An edge arriving on a saturated counter is a timeout, never a measurement.
    assign saturated = (count == PERIOD_MAX);
    assign capture   = rise && !saturated && (state != SILENT);

    always_comb begin
        cur_match = match_period(count);
    end

    always_ff @(posedge CLK_50M) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (rise) begin
            count <= PERIOD_W'(1);
        end else if (!saturated) begin
            count <= count + PERIOD_W'(1);
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (!RESET_N) begin
            state          <= SILENT;
            cand           <= DO;
            note_q         <= DO;
            locked_q       <= 1'b0;
            period_valid_q <= 1'b0;
        end else begin
            period_valid_q <= capture;
            if (saturated) begin
                state    <= SILENT;
                locked_q <= 1'b0;
            end else if (rise) begin
                case (state)
                    SILENT: state <= ARM;
                    ARM: begin
                        if (cur_match.hit) begin
                            state <= MEASURE;
                            cand  <= cur_match.note;
                        end
                    end
                    MEASURE: begin
                        if (!cur_match.hit) begin
                            state <= ARM;
                        end else if (cur_match.note == cand) begin
                            state    <= LOCKED;
                            note_q   <= cur_match.note;
                            locked_q <= 1'b1;
                        end else begin
                            cand <= cur_match.note;
                        end
                    end
                    LOCKED: begin
                        if (!cur_match.hit || cur_match.note != note_q) begin
                            locked_q <= 1'b0;
                            if (cur_match.hit) begin
                                state <= MEASURE;
                                cand  <= cur_match.note;
                            end else begin
                                state <= ARM;
                            end
                        end
                    end
                    default: state <= SILENT;
                endcase
            end
        end
    end

    assign bus.note         = note_q;
    assign bus.locked       = locked_q;
    assign bus.period_valid = period_valid_q;

`ifdef TONE_DECODER_INFO_EN
    logic [PERIOD_W-1:0] info_q;

    always_ff @(posedge CLK_50M) begin
        if (!RESET_N) begin
            info_q <= '0;
        end else if (capture) begin
            info_q <= count;
        end
    end

    assign bus.info = {{(32-PERIOD_W){1'b0}}, info_q};
`else
    assign bus.info = '0;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder: reference model locks when two consecutive
// measured periods classify to the same note since the last silence/reset.
module tb_tone_decoder;

    localparam int FP [0:7] = '{95602, 85178, 75872, 71634, 63856, 56818, 50658, 47802};
    localparam int SAT = 262143;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // reference model state
    bit m_armed;
    bit m_locked;
    bit m_capture;
    int m_note;
    int m_info;
    int m_prev;
    int m_last;

    tone_decoder_if tif ();

    tone_decoder dut (
        .CLK_50M (clk),
        .RESET_N (rst_n),
        .bus     (tif)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100_000_000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int classify(input int p);
        int d;
        for (int n = 0; n < 8; n++) begin
            d = (p > FP[n]) ? p - FP[n] : FP[n] - p;
            if (d <= FP[n] / 64) return n;
        end
        return -1;
    endfunction

    function automatic int exp_info();
`ifdef TONE_DECODER_INFO_EN
        return m_info;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_armed = 0; m_locked = 0; m_capture = 0;
        m_note = 0; m_info = 0; m_prev = -1; m_last = cyc;
    endtask

    task automatic model_edge(input int gap);
        int c;
        m_capture = 0;
        if (gap >= SAT) begin
            m_armed = 0; m_locked = 0; m_prev = -1;
        end else if (!m_armed) begin
            m_armed = 1; m_prev = -1;
        end else begin
            c = classify(gap);
            m_capture = 1;
            m_info = gap;
            if (c >= 0 && c == m_prev) begin
                m_locked = 1; m_note = c;
            end else begin
                m_locked = 0;
            end
            m_prev = c;
        end
    endtask

    task automatic rise_edge();
        @(posedge clk); #1;
        tif.audio_in = 1'b1;
        model_edge(cyc - m_last);
        m_last = cyc;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic finish_period(input int h, input int p);
        while (cyc < m_last + h) begin @(posedge clk); #1; end
        tif.audio_in = 1'b0;
        while (cyc < m_last + p - 1) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            tif.audio_in = 1'($urandom_range(0, 1));
            checks++; if (tif.locked !== 1'b0) begin failures++; $display("[TB] FAIL reset.locked got=%0b exp=0", tif.locked); end
            checks++; if (tif.note !== 3'd0) begin failures++; $display("[TB] FAIL reset.note got=%0d exp=0", tif.note); end
            checks++; if (tif.period_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset.period_valid got=%0b exp=0", tif.period_valid); end
            checks++; if (tif.info !== 32'd0) begin failures++; $display("[TB] FAIL reset.info got=%0d exp=0", tif.info); end
        end
        tif.audio_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_do_lock();
        for (int e = 0; e < 3; e++) begin
            rise_edge();
            checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL do.locked edge=%0d got=%0b exp=%0b", e, tif.locked, m_locked); end
            checks++; if (tif.note !== 3'(m_note)) begin failures++; $display("[TB] FAIL do.note edge=%0d got=%0d exp=%0d", e, tif.note, m_note); end
            checks++; if (tif.period_valid !== m_capture) begin failures++; $display("[TB] FAIL do.period_valid edge=%0d got=%0b exp=%0b", e, tif.period_valid, m_capture); end
            checks++; if (tif.info !== 32'(exp_info())) begin failures++; $display("[TB] FAIL do.info edge=%0d got=%0d exp=%0d", e, tif.info, exp_info()); end
            @(posedge clk); #1;
            checks++; if (tif.period_valid !== 1'b0) begin failures++; $display("[TB] FAIL do.pv_one_cycle edge=%0d got=%0b exp=0", e, tif.period_valid); end
            finish_period(47801, 95602);
        end
    endtask

    task automatic test_la_switch();
        for (int e = 0; e < 3; e++) begin
            rise_edge();
            checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL la.locked edge=%0d got=%0b exp=%0b", e, tif.locked, m_locked); end
            checks++; if (tif.note !== 3'(m_note)) begin failures++; $display("[TB] FAIL la.note edge=%0d got=%0d exp=%0d", e, tif.note, m_note); end
            checks++; if (tif.period_valid !== m_capture) begin failures++; $display("[TB] FAIL la.period_valid edge=%0d got=%0b exp=%0b", e, tif.period_valid, m_capture); end
            checks++; if (tif.info !== 32'(exp_info())) begin failures++; $display("[TB] FAIL la.info edge=%0d got=%0d exp=%0d", e, tif.info, exp_info()); end
            finish_period(28409, 56818);
        end
    endtask

    task automatic test_no_match();
        for (int e = 0; e < 3; e++) begin
            rise_edge();
            checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL nomatch.locked edge=%0d got=%0b exp=%0b", e, tif.locked, m_locked); end
            checks++; if (tif.note !== 3'(m_note)) begin failures++; $display("[TB] FAIL nomatch.note edge=%0d got=%0d exp=%0d", e, tif.note, m_note); end
            checks++; if (tif.period_valid !== m_capture) begin failures++; $display("[TB] FAIL nomatch.period_valid edge=%0d got=%0b exp=%0b", e, tif.period_valid, m_capture); end
            checks++; if (tif.info !== 32'(exp_info())) begin failures++; $display("[TB] FAIL nomatch.info edge=%0d got=%0d exp=%0d", e, tif.info, exp_info()); end
            finish_period($urandom_range(1000, 79000), 80000);
        end
    endtask

    task automatic test_boundary();
        int periods [0:4] = '{72753, 72753, 72754, 72753, 50658};
        for (int e = 0; e < 5; e++) begin
            rise_edge();
            checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL fa_bound.locked edge=%0d got=%0b exp=%0b", e, tif.locked, m_locked); end
            checks++; if (tif.note !== 3'(m_note)) begin failures++; $display("[TB] FAIL fa_bound.note edge=%0d got=%0d exp=%0d", e, tif.note, m_note); end
            checks++; if (tif.period_valid !== m_capture) begin failures++; $display("[TB] FAIL fa_bound.period_valid edge=%0d got=%0b exp=%0b", e, tif.period_valid, m_capture); end
            checks++; if (tif.info !== 32'(exp_info())) begin failures++; $display("[TB] FAIL fa_bound.info edge=%0d got=%0d exp=%0d", e, tif.info, exp_info()); end
            finish_period($urandom_range(8, periods[e] - 8), periods[e]);
        end
    endtask

    task automatic test_timeout();
        int act;
        for (int e = 0; e < 2; e++) begin
            rise_edge();
            checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL si_lock.locked edge=%0d got=%0b exp=%0b", e, tif.locked, m_locked); end
            checks++; if (tif.note !== 3'(m_note)) begin failures++; $display("[TB] FAIL si_lock.note edge=%0d got=%0d exp=%0d", e, tif.note, m_note); end
            if (e == 0) finish_period(25329, 50658);
        end
        act = m_last + 3;
        repeat (100) @(posedge clk);
        #1 tif.audio_in = 1'b0;
        while (cyc < act + SAT - 1) begin @(posedge clk); #1; end
        checks++; if (tif.locked !== 1'b1) begin failures++; $display("[TB] FAIL timeout.early got=%0b exp=1", tif.locked); end
        @(posedge clk); #1;
        m_locked = 0; m_armed = 0; m_prev = -1;
        checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL timeout.locked got=%0b exp=%0b", tif.locked, m_locked); end
        checks++; if (tif.note !== 3'(m_note)) begin failures++; $display("[TB] FAIL timeout.note got=%0d exp=%0d", tif.note, m_note); end
        for (int e = 0; e < 3; e++) begin
            rise_edge();
            checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL after_silence.locked edge=%0d got=%0b exp=%0b", e, tif.locked, m_locked); end
            checks++; if (tif.period_valid !== m_capture) begin failures++; $display("[TB] FAIL after_silence.period_valid edge=%0d got=%0b exp=%0b", e, tif.period_valid, m_capture); end
            checks++; if (tif.info !== 32'(exp_info())) begin failures++; $display("[TB] FAIL after_silence.info edge=%0d got=%0d exp=%0d", e, tif.info, exp_info()); end
            finish_period($urandom_range(8, 50650), 50658);
        end
    endtask

    task automatic test_reset_mid();
        int old_rise;
        for (int e = 0; e < 2; e++) begin
            rise_edge();
            checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL re_pre.locked edge=%0d got=%0b exp=%0b", e, tif.locked, m_locked); end
            if (e == 0) finish_period(42589, 85178);
        end
        old_rise = m_last;
        finish_period(42589, 60000);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (tif.locked !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset.locked got=%0b exp=0", tif.locked); end
            checks++; if (tif.note !== 3'd0) begin failures++; $display("[TB] FAIL mid_reset.note got=%0d exp=0", tif.note); end
            checks++; if (tif.period_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset.period_valid got=%0b exp=0", tif.period_valid); end
            checks++; if (tif.info !== 32'd0) begin failures++; $display("[TB] FAIL mid_reset.info got=%0d exp=0", tif.info); end
        end
        rst_n = 1'b1;
        model_reset();
        while (cyc < old_rise + 85177) begin @(posedge clk); #1; end
        for (int e = 0; e < 3; e++) begin
            rise_edge();
            checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL re_post.locked edge=%0d got=%0b exp=%0b", e, tif.locked, m_locked); end
            checks++; if (tif.note !== 3'(m_note)) begin failures++; $display("[TB] FAIL re_post.note edge=%0d got=%0d exp=%0d", e, tif.note, m_note); end
            checks++; if (tif.period_valid !== m_capture) begin failures++; $display("[TB] FAIL re_post.period_valid edge=%0d got=%0b exp=%0b", e, tif.period_valid, m_capture); end
            finish_period(42589, 85178);
        end
    endtask

    task automatic test_random();
        int n, tol, p;
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) n = $urandom_range(0, 7);
            tol = FP[n] / 64;
            p = FP[n] - tol + $urandom_range(0, 2 * tol);
            if ($urandom_range(0, 3) == 0) p = FP[n] + tol + 1 + $urandom_range(0, 300);
            rise_edge();
            checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL random.locked k=%0d got=%0b exp=%0b", k, tif.locked, m_locked); end
            checks++; if (tif.note !== 3'(m_note)) begin failures++; $display("[TB] FAIL random.note k=%0d got=%0d exp=%0d", k, tif.note, m_note); end
            checks++; if (tif.period_valid !== m_capture) begin failures++; $display("[TB] FAIL random.period_valid k=%0d got=%0b exp=%0b", k, tif.period_valid, m_capture); end
            checks++; if (tif.info !== 32'(exp_info())) begin failures++; $display("[TB] FAIL random.info k=%0d got=%0d exp=%0d", k, tif.info, exp_info()); end
            finish_period($urandom_range(8, p - 8), p);
        end
        rise_edge();
        checks++; if (tif.locked !== m_locked) begin failures++; $display("[TB] FAIL random.final_locked got=%0b exp=%0b", tif.locked, m_locked); end
        checks++; if (tif.info !== 32'(exp_info())) begin failures++; $display("[TB] FAIL random.final_info got=%0d exp=%0d", tif.info, exp_info()); end
    endtask

    initial begin
        tif.audio_in = 1'b0;
        model_reset();
        test_reset();
        test_do_lock();
        test_la_switch();
        test_no_match();
        test_boundary();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
